// File: rtl/ts_pair_timestamper.sv
// Start/end event pairing timestamper: stamps events with a free-running counter,
// matches ends against a pending-start table and queues {id, start, end, delta} records.

module ts_pair_slot #(
  parameter int ID_W = 16,
  parameter int TS_W = 64
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_end_valid,
  input  logic [ID_W-1:0] i_end_id,
  input  logic            i_start_valid,
  input  logic [ID_W-1:0] i_start_id,
  input  logic            i_wr,
  input  logic [TS_W-1:0] i_ts,
  output logic            o_vld,
  output logic [TS_W-1:0] o_ts,
  output logic            o_end_hit,
  output logic            o_start_hit
);
  logic            r_vld;
  logic [ID_W-1:0] r_id;
  logic [TS_W-1:0] r_ts;

  assign o_vld       = r_vld;
  assign o_ts        = r_ts;
  assign o_end_hit   = i_end_valid & r_vld & (r_id == i_end_id);
  // a slot closed by this cycle's end no longer counts as holding the id
  assign o_start_hit = i_start_valid & r_vld & ~o_end_hit & (r_id == i_start_id);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vld <= 1'b0;
      r_id  <= '0;
      r_ts  <= '0;
    end else if (i_wr) begin
      r_vld <= 1'b1;
      r_id  <= i_start_id;
      r_ts  <= i_ts;
    end else if (o_end_hit) begin
      r_vld <= 1'b0;
    end
  end
endmodule

module ts_pair_timestamper #(
  parameter int ID_W      = 16,
  parameter int TS_W      = 64,
  parameter int SLOTS     = 8,
  parameter int OUT_DEPTH = 4,
  parameter int CNT_W     = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start_valid,
  input  logic [ID_W-1:0]  i_start_id,
  input  logic             i_end_valid,
  input  logic [ID_W-1:0]  i_end_id,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [ID_W-1:0]  o_out_id,
  output logic [TS_W-1:0]  o_out_start_ts,
  output logic [TS_W-1:0]  o_out_end_ts,
  output logic [TS_W-1:0]  o_out_delta,
  output logic [TS_W-1:0]  o_ts_now,
  output logic [CNT_W-1:0] o_drop_full_cnt,
  output logic [CNT_W-1:0] o_orphan_cnt,
  output logic [CNT_W-1:0] o_ovf_cnt
);
  localparam int PW = $clog2(OUT_DEPTH);
  localparam int CW = $clog2(OUT_DEPTH + 1);

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [TS_W-1:0] sts;
    logic [TS_W-1:0] ets;
    logic [TS_W-1:0] dlt;
  } rec_t;

  logic [TS_W-1:0]               r_ts;
  logic [SLOTS-1:0]              w_vld, w_end_hit, w_start_hit, w_free, w_alloc, w_wr;
  logic [SLOTS-1:0][TS_W-1:0]    w_slot_ts;
  logic [TS_W-1:0]               w_hit_ts;
  logic                          w_any_end, w_any_start_hit, w_found, w_drop;
  rec_t [OUT_DEPTH-1:0]          r_mem;
  logic [PW-1:0]                 r_wp, r_rp;
  logic [CW-1:0]                 r_cnt;
  logic                          w_full, w_pop, w_push, w_ovf;
  rec_t                          w_rec, w_head;
  logic [CNT_W-1:0]              r_drop, r_orphan, r_ovf;

  for (genvar g = 0; g < SLOTS; g++) begin : g_slot
    ts_pair_slot #(.ID_W(ID_W), .TS_W(TS_W)) u_slot (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_end_valid(i_end_valid), .i_end_id(i_end_id),
      .i_start_valid(i_start_valid), .i_start_id(i_start_id),
      .i_wr(w_wr[g]), .i_ts(r_ts),
      .o_vld(w_vld[g]), .o_ts(w_slot_ts[g]),
      .o_end_hit(w_end_hit[g]), .o_start_hit(w_start_hit[g])
    );
  end

  assign w_any_end       = |w_end_hit;
  assign w_any_start_hit = |w_start_hit;
  assign w_free          = ~(w_vld & ~w_end_hit);

  // hits are unique, so an OR-reduce acts as the slot mux
  always_comb begin
    w_hit_ts = '0;
    for (int i = 0; i < SLOTS; i++)
      if (w_end_hit[i]) w_hit_ts = w_hit_ts | w_slot_ts[i];
  end

  always_comb begin
    w_alloc = '0;
    w_found = 1'b0;
    for (int i = 0; i < SLOTS; i++)
      if (w_free[i] && !w_found) begin
        w_alloc[i] = 1'b1;
        w_found    = 1'b1;
      end
  end

  assign w_wr   = w_any_start_hit ? w_start_hit : (i_start_valid ? w_alloc : '0);
  assign w_drop = i_start_valid & ~w_any_start_hit & ~w_found;

  assign w_rec.id  = i_end_id;
  assign w_rec.sts = w_hit_ts;
  assign w_rec.ets = r_ts;
  assign w_rec.dlt = r_ts - w_hit_ts;

  assign w_full  = (r_cnt == CW'(OUT_DEPTH));
  assign w_pop   = o_out_valid & i_out_ready;
  assign w_push  = w_any_end & (~w_full | w_pop);
  assign w_ovf   = w_any_end & w_full & ~w_pop;
  assign w_head  = r_mem[r_rp];

  assign o_out_valid     = (r_cnt != '0);
  assign o_out_id        = w_head.id;
  assign o_out_start_ts  = w_head.sts;
  assign o_out_end_ts    = w_head.ets;
  assign o_out_delta     = w_head.dlt;
  assign o_ts_now        = r_ts;
  assign o_drop_full_cnt = r_drop;
  assign o_orphan_cnt    = r_orphan;
  assign o_ovf_cnt       = r_ovf;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ts  <= '0;
      r_mem <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      r_ts <= r_ts + TS_W'(1);
      if (w_push) begin
        r_mem[r_wp] <= w_rec;
        r_wp        <= r_wp + PW'(1);
      end
      if (w_pop) r_rp <= r_rp + PW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_drop   <= '0;
      r_orphan <= '0;
      r_ovf    <= '0;
    end else begin
      if (w_drop && r_drop != '1)                      r_drop   <= r_drop + CNT_W'(1);
      if (i_end_valid && !w_any_end && r_orphan != '1) r_orphan <= r_orphan + CNT_W'(1);
      if (w_ovf && r_ovf != '1)                        r_ovf    <= r_ovf + CNT_W'(1);
    end
  end
endmodule
